// File: rtl/mips_rtype_exec_ctrl_if.sv
// Instruction handshake and ALU drive/return bundle for the R-type execution controller.
// master = host/ALU side, slave = controller side.
interface mips_rtype_exec_ctrl_if;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [2:0]  alu_sel;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_res;
    logic        alu_zero;
    logic        alu_ovf;

    modport master (
        output instr_valid, instr, alu_res, alu_zero, alu_ovf,
        input  instr_ready, alu_sel, alu_a, alu_b
    );

    modport slave (
        input  instr_valid, instr, alu_res, alu_zero, alu_ovf,
        output instr_ready, alu_sel, alu_a, alu_b
    );
endinterface

// File: rtl/mips_rtype_exec_ctrl.sv
// Four-state (IDLE/DEC/EXE/WB) R-type execution controller driving an external combinational ALU,
// with a 32x32 register file and a combinational debug read port.
module mips_rtype_exec_ctrl (
    input  logic                         clk,
    input  logic                         rst_n,
    mips_rtype_exec_ctrl_if.slave        bus,
    output logic                         done,
    output logic                         illegal,
    output logic                         ovf_exc,
    output logic                         zero_flag,
    input  logic [4:0]                   dbg_addr,
    output logic [31:0]                  dbg_data
);

    typedef enum logic [1:0] {IDLE, DEC, EXE, WB} state_t;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_NOR = 6'h27;

    state_t      state, state_nxt;
    logic [31:0] instr_q;
    logic [31:0] regs [32];

    logic [2:0]  sel_q;
    logic [31:0] a_q, b_q;
    logic        illegal_q, addsub_q;
    logic [31:0] res_q;
    logic        zero_q, ovf_q;

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [31:0] rs_val, rt_val;

    logic [2:0]  dec_sel;
    logic [31:0] dec_a, dec_b;
    logic        dec_illegal, dec_addsub;

    assign opcode = instr_q[31:26];
    assign rs     = instr_q[25:21];
    assign rt     = instr_q[20:16];
    assign rd     = instr_q[15:11];
    assign shamt  = instr_q[10:6];
    assign funct  = instr_q[5:0];

    // $0 is forced to zero on every read path regardless of array contents
    assign rs_val   = (rs == 5'd0) ? 32'd0 : regs[rs];
    assign rt_val   = (rt == 5'd0) ? 32'd0 : regs[rt];
    assign dbg_data = (dbg_addr == 5'd0) ? 32'd0 : regs[dbg_addr];

    assign bus.instr_ready = rst_n && (state == IDLE);
    assign bus.alu_sel     = sel_q;
    assign bus.alu_a       = a_q;
    assign bus.alu_b       = b_q;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.instr_valid) state_nxt = DEC;
            DEC:     state_nxt = EXE;
            EXE:     state_nxt = WB;
            WB:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        dec_sel     = 3'b000;
        dec_a       = 32'd0;
        dec_b       = 32'd0;
        dec_illegal = 1'b0;
        dec_addsub  = 1'b0;
        if (opcode != 6'd0) begin
            dec_illegal = 1'b1;
        end else begin
            case (funct)
                FN_ADD: begin dec_sel = 3'b010; dec_a = rs_val; dec_b = rt_val; dec_addsub = 1'b1; end
                FN_SUB: begin dec_sel = 3'b100; dec_a = rs_val; dec_b = rt_val; dec_addsub = 1'b1; end
                FN_AND: begin dec_sel = 3'b000; dec_a = rs_val; dec_b = rt_val; end
                FN_OR:  begin dec_sel = 3'b001; dec_a = rs_val; dec_b = rt_val; end
                FN_XOR: begin dec_sel = 3'b011; dec_a = rs_val; dec_b = rt_val; end
                FN_NOR: begin dec_sel = 3'b111; dec_a = rs_val; dec_b = rt_val; end
                FN_SLL: begin dec_sel = 3'b110; dec_a = rt_val; dec_b = {27'd0, shamt}; end
                FN_SRL: begin dec_sel = 3'b101; dec_a = rt_val; dec_b = {27'd0, shamt}; end
                default: dec_illegal = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instr_q   <= 32'd0;
            sel_q     <= 3'b000;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            illegal_q <= 1'b0;
            addsub_q  <= 1'b0;
            res_q     <= 32'd0;
            zero_q    <= 1'b0;
            ovf_q     <= 1'b0;
            done      <= 1'b0;
            illegal   <= 1'b0;
            ovf_exc   <= 1'b0;
            zero_flag <= 1'b0;
            for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (bus.instr_valid) instr_q <= bus.instr;
                DEC: begin
                    sel_q     <= dec_sel;
                    a_q       <= dec_a;
                    b_q       <= dec_b;
                    illegal_q <= dec_illegal;
                    addsub_q  <= dec_addsub;
                end
                EXE: begin
                    res_q  <= bus.alu_res;
                    zero_q <= bus.alu_zero;
                    // overflow only means something for add/sub
                    ovf_q  <= bus.alu_ovf & addsub_q;
                end
                WB: begin
                    if (!illegal_q && !ovf_q && (rd != 5'd0)) regs[rd] <= res_q;
                    done      <= 1'b1;
                    illegal   <= illegal_q;
                    ovf_exc   <= illegal_q ? 1'b0 : ovf_q;
                    zero_flag <= illegal_q ? 1'b0 : zero_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mips_rtype_exec_ctrl.md
MIPS_RTYPE_EXEC_CTRL -- requirements
Module: mips_rtype_exec_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: clk input 1, rising-edge clock; rst_n input 1, sampled only on the rising edge of clk.
REQ-002 The instruction port SHALL be: instr_valid input 1, instruction offered; instr_ready output 1, block can accept; instr input 32, MIPS R-type word.
REQ-003 The ALU drive port SHALL be: alu_sel output 3, operation select; alu_a output 32, operand A; alu_b output 32, operand B.
REQ-004 The ALU return port SHALL be: alu_res input 32, combinational ALU result; alu_zero input 1, result==0; alu_ovf input 1, signed overflow.
REQ-005 The status port SHALL be: done output 1, one-cycle completion pulse; illegal output 1, last instruction unsupported; ovf_exc output 1, last add/sub overflowed; zero_flag output 1, last result zero.
REQ-006 The debug port SHALL be: dbg_addr input 5, register index; dbg_data output 32, combinational read of that register.

Function
REQ-007 The block SHALL contain a 32x32 register file; $0 SHALL read as 0 and SHALL never be written.
REQ-008 The state machine SHALL have the states IDLE, DEC, EXE and WB, with transitions IDLE->DEC on instr_valid&instr_ready, DEC->EXE, EXE->WB and WB->IDLE unconditionally.
REQ-009 instr_ready SHALL be 1 only in IDLE; instr_valid SHALL be ignored in every other state.
REQ-010 On acceptance, instr SHALL be latched; the rs, rt, rd, shamt and funct fields SHALL come only from the latched copy.
REQ-011 In DEC, the block SHALL latch operands and decode, with alu_sel/alu_a/alu_b registered as follows:
- add (funct 0x20): sel 010, a=R[rs], b=R[rt]
- sub (0x22): sel 100, a=R[rs], b=R[rt]
- and (0x24): sel 000, a=R[rs], b=R[rt]
- or (0x25): sel 001, a=R[rs], b=R[rt]
- xor (0x26): sel 011, a=R[rs], b=R[rt]
- nor (0x27): sel 111, a=R[rs], b=R[rt]
- sll (0x00): sel 110, a=R[rt], b={27'b0,shamt}
- srl (0x02): sel 101, a=R[rt], b={27'b0,shamt}
REQ-012 Opcode (instr[31:26]) !=0 or any other funct SHALL be illegal, with alu_sel=000, alu_a=0 and alu_b=0.
REQ-013 alu_sel, alu_a and alu_b SHALL be stable from the DEC->EXE edge until the next DEC->EXE edge.
REQ-014 At the EXE->WB edge, alu_res, alu_zero and alu_ovf SHALL be captured; alu_ovf SHALL be honoured only for add/sub and masked to 0 otherwise.
REQ-015 At the WB->IDLE edge, R[rd] SHALL be written with the captured result, except when rd==0, the instruction is illegal, or masked overflow is 1.
REQ-016 At the WB->IDLE edge, done SHALL go to 1 for exactly one cycle, and illegal, ovf_exc and zero_flag SHALL update and hold until the next done.
REQ-017 For an illegal instruction, zero_flag and ovf_exc SHALL update to 0.
REQ-018 Latency SHALL be fixed: with acceptance at edge E0, the write and done rise SHALL occur at E3; maximum throughput SHALL be one instruction per 4 cycles.
REQ-019 Because completion precedes the next decode, a read-after-write between consecutive instructions SHALL always observe the new value.
REQ-020 dbg_data SHALL reflect a write in the cycle after the write edge, with no interaction with the FSM.

Reset
REQ-021 With rst_n=0 at a rising edge, the state SHALL become IDLE and the following SHALL clear to 0: all registers, latched instr, alu_sel, alu_a, alu_b, captured result, done, illegal, ovf_exc and zero_flag.
REQ-022 instr_ready SHALL be 0 while rst_n=0 and SHALL be 1 in the first cycle after release.
REQ-023 A reset asserted in DEC, EXE or WB SHALL abort the instruction with no register write and no done pulse.

Verification
REQ-024 Write R1=5 and R2=7 via preceding add-immediate-free setup (addu chain from reset not available; preload through sequences such as nor $1,$0,$0 and then sub), then add $3,$1,$2 -> done at E3, R3=12, zero_flag=0, ovf_exc=0.
REQ-025 R1=0x7FFFFFFF, R2=1, add $4,$1,$2 -> ovf_exc=1, R4 unchanged; the same operands with or $4,$1,$2 -> R4=0x7FFFFFFF, ovf_exc=0.
REQ-026 R5=0x80000001, sll $6,$5,4 -> alu_a=0x80000001, alu_b=4, R6=0x00000010; srl $7,$5,31 -> R7=1.
REQ-027 Opcode 0x08 word, or funct 0x18 -> illegal=1, done pulses, no register changes; add $0,$1,$1 -> R0 reads 0.
REQ-028 Hold instr_valid high continuously -> instr_ready toggles 1 in IDLE only, one done every 4 cycles, with back-to-back dependent xor $8,$8,$9 results correct.
REQ-029 rst_n low in EXE of sub $10,$1,$2 -> no done, R10=0, instr_ready=1 the cycle after release.
